// File: rtl/data_mem_responder_if.sv
// Core data-port bundle: memory-stage access in, load data back.
interface data_mem_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] RWAddress;
  logic [31:0] WriteData;
  logic [31:0] MemData;

  modport master (output MemRead, output MemWrite, output RWAddress, output WriteData,
                  input MemData);
  modport slave  (input MemRead, input MemWrite, input RWAddress, input WriteData,
                  output MemData);
endinterface

// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM plus an MMIO page with GPIO, timer/compare
// and sticky status / first-fault address capture.
module data_mem_responder #(
  parameter logic [31:0] RAM_BASE   = 32'h1001_0000,
  parameter int unsigned RAM_WORDS  = 64,
  parameter logic [31:0] IO_BASE    = 32'h1001_0400,
  parameter int unsigned GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_if.slave             bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq,
  output logic                  bus_err
);

  localparam int unsigned AW      = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(4 * RAM_WORDS);
  localparam logic [32:0] IO_END  = {1'b0, IO_BASE} + 33'd32;

  logic [31:0]           mem [RAM_WORDS];
  logic [GPIO_WIDTH-1:0] gpio_q, gpio_d;
  logic [GPIO_WIDTH-1:0] sync1, sync2;
  logic [31:0]           count_q, count_d;
  logic [31:0]           cmp_q, cmp_d;
  logic [2:0]            status_q, status_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic          aligned, ram_hit, io_hit, mapped, access, conflict, fault;
  logic          wr_ok, ram_we, io_we;
  logic [AW-1:0] ram_idx;
  logic [2:0]    io_idx;
  logic [31:0]   io_rdata;

  // Address decode and access classification
  assign aligned  = (bus.RWAddress[1:0] == 2'b00);
  assign ram_hit  = ({1'b0, bus.RWAddress} >= {1'b0, RAM_BASE}) && ({1'b0, bus.RWAddress} < RAM_END);
  assign io_hit   = ({1'b0, bus.RWAddress} >= {1'b0, IO_BASE}) && ({1'b0, bus.RWAddress} < IO_END);
  assign mapped   = ram_hit | io_hit;
  assign access   = bus.MemRead | bus.MemWrite;
  assign conflict = bus.MemRead & bus.MemWrite;
  assign fault    = (access && (!aligned || !mapped)) || conflict;
  assign wr_ok    = bus.MemWrite && aligned && mapped;
  assign ram_we   = wr_ok && ram_hit;
  assign io_we    = wr_ok && io_hit;
  assign ram_idx  = AW'((bus.RWAddress[AW+1:0] - RAM_BASE[AW+1:0]) >> 2);
  assign io_idx   = 3'((bus.RWAddress[4:0] - IO_BASE[4:0]) >> 2);

  always_comb begin
    io_rdata = '0;
    case (io_idx)
      3'd0:    io_rdata = 32'(gpio_q);
      3'd1:    io_rdata = 32'(sync2);
      3'd2:    io_rdata = count_q;
      3'd3:    io_rdata = cmp_q;
      3'd4:    io_rdata = 32'(status_q);
      3'd5:    io_rdata = err_addr_q;
      default: io_rdata = '0;
    endcase
  end

  // Load data is combinational from the current address and pre-edge state
  always_comb begin
    bus.MemData = '0;
    if (bus.MemRead && aligned) begin
      if (ram_hit)     bus.MemData = mem[ram_idx];
      else if (io_hit) bus.MemData = io_rdata;
    end
  end

  // Hardware status sets are applied after W1C so they win the same cycle
  always_comb begin
    gpio_d     = gpio_q;
    count_d    = count_q + 32'd1;
    cmp_d      = cmp_q;
    status_d   = status_q;
    err_addr_d = err_addr_q;
    if (io_we) begin
      case (io_idx)
        3'd0:    gpio_d   = bus.WriteData[GPIO_WIDTH-1:0];
        3'd2:    count_d  = bus.WriteData;
        3'd3:    cmp_d    = bus.WriteData;
        3'd4:    status_d = status_q & ~bus.WriteData[2:0];
        default: ;
      endcase
    end
    if (count_q == cmp_q) status_d[0] = 1'b1;
    if (fault) begin
      status_d[1] = 1'b1;
      if (!status_q[1]) err_addr_d = bus.RWAddress;
    end
    if (conflict) status_d[2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q     <= '0;
      sync1      <= '0;
      sync2      <= '0;
      count_q    <= '0;
      cmp_q      <= '1;
      status_q   <= '0;
      err_addr_q <= '0;
    end else begin
      gpio_q     <= gpio_d;
      sync1      <= gpio_in;
      sync2      <= sync1;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      status_q   <= status_d;
      err_addr_q <= err_addr_d;
    end
  end

  // RAM has no reset; a store coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (!rst && ram_we) mem[ram_idx] <= bus.WriteData;
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = status_q[0];
  assign bus_err   = status_q[1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios, then randomized traffic
// checked every cycle against a behavioural memory-map model.
module tb_data_mem_responder;

  localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] IO_BASE   = 32'h1001_0400;
  localparam int          RAM_WORDS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       timer_irq;
  logic       bus_err;

  data_mem_if bus();

  data_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the memory map
  logic [31:0] m_ram   [RAM_WORDS];
  bit          m_known [RAM_WORDS];
  logic [7:0]  m_gpio, m_g1, m_g2;
  logic [31:0] m_count, m_cmp, m_err;
  logic [2:0]  m_status;
  bit          m_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    if (a >= RAM_BASE && a < RAM_BASE + 32'(4 * RAM_WORDS)) return 1;
    if (a >= IO_BASE && a < IO_BASE + 32'd32) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] io_val(input logic [31:0] off);
    case (off)
      32'h00:  return 32'(m_gpio);
      32'h04:  return 32'(m_g2);
      32'h08:  return m_count;
      32'h0C:  return m_cmp;
      32'h10:  return 32'(m_status);
      32'h14:  return m_err;
      default: return 32'd0;
    endcase
  endfunction

  // Returns 0 when the expected value depends on never-written RAM
  function automatic bit exp_read(input logic rd, input logic [31:0] a, output logic [31:0] v);
    int idx;
    v = 32'd0;
    if (!rd || a[1:0] != 2'b00) return 1'b1;
    case (region(a))
      1: begin
        idx = int'((a - RAM_BASE) >> 2);
        v = m_ram[idx];
        return m_known[idx];
      end
      2:       begin v = io_val(a - IO_BASE); return 1'b1; end
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] a, wd, new_count;
    logic [2:0]  new_status;
    logic        rd, wr, bad, conf, matched;
    int          reg_kind, idx;
    a = bus.RWAddress; wd = bus.WriteData; rd = bus.MemRead; wr = bus.MemWrite;
    if (rst) begin
      m_gpio = 8'd0; m_g1 = 8'd0; m_g2 = 8'd0;
      m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_status = 3'd0; m_err = 32'd0;
      m_ok = 1'b1;
      return;
    end
    reg_kind   = region(a);
    bad        = (rd || wr) && (a[1:0] != 2'b00 || reg_kind == 0);
    conf       = rd && wr;
    matched    = (m_count == m_cmp);
    new_count  = m_count + 32'd1;
    new_status = m_status;
    if (wr && a[1:0] == 2'b00 && reg_kind == 1) begin
      idx = int'((a - RAM_BASE) >> 2);
      m_ram[idx] = wd;
      m_known[idx] = 1'b1;
    end else if (wr && a[1:0] == 2'b00 && reg_kind == 2) begin
      case (a - IO_BASE)
        32'h00:  m_gpio = wd[7:0];
        32'h08:  new_count = wd;
        32'h0C:  m_cmp = wd;
        32'h10:  new_status = new_status & ~wd[2:0];
        default: ;
      endcase
    end
    if (matched) new_status[0] = 1'b1;
    if (bad || conf) begin
      if (!m_status[1]) m_err = a;
      new_status[1] = 1'b1;
    end
    if (conf) new_status[2] = 1'b1;
    m_g2 = m_g1;
    m_g1 = gpio_in;
    m_count = new_count;
    m_status = new_status;
  endtask

  always @(posedge clk) model_step();

  task automatic compare_outputs();
    logic [31:0] v;
    if (exp_read(bus.MemRead, bus.RWAddress, v)) chk("MemData", bus.MemData, v);
    chk("gpio_out", 32'(gpio_out), 32'(m_gpio));
    chk("timer_irq", 32'(timer_irq), 32'(m_status[0]));
    chk("bus_err", 32'(bus_err), 32'(m_status[1]));
  endtask

  always @(negedge clk) if (m_ok) compare_outputs();

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.MemRead = rd; bus.MemWrite = wr; bus.RWAddress = a; bus.WriteData = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return RAM_BASE + 32'(4 * $urandom_range(0, RAM_WORDS - 1));
      4:          return ($urandom_range(0, 1) == 0) ? RAM_BASE + 32'h0FC : RAM_BASE + 32'h100;
      5, 6:       return IO_BASE + 32'(4 * $urandom_range(0, 7));
      7:          return ($urandom_range(0, 1) == 0) ? IO_BASE + 32'h20 : IO_BASE - 32'd4;
      8:          return RAM_BASE + 32'(4 * $urandom_range(0, 80)) + 32'($urandom_range(1, 3));
      default:    return 32'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    gpio_in = 8'd0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Reset state and free-running count
    drive(1'b1, 1'b0, IO_BASE + 32'h8, 32'd0);
    chk("count_at_0", bus.MemData, 32'd0);
    chk("rst_gpio_out", 32'(gpio_out), 32'd0);
    chk("rst_timer_irq", 32'(timer_irq), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    tick();
    drive(1'b1, 1'b0, IO_BASE + 32'h8, 32'd0);
    chk("count_at_1", bus.MemData, 32'd1);
    tick();
    drive(1'b0, 1'b0, IO_BASE + 32'h8, 32'd0);
    chk("idle_memdata", bus.MemData, 32'd0);
    tick();

    // RAM write/read, last word, past end
    drive(1'b0, 1'b1, RAM_BASE + 32'h4, 32'hDEAD_BEEF); tick();
    drive(1'b1, 1'b0, RAM_BASE + 32'h4, 32'd0);
    chk("ram_word1", bus.MemData, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b1, RAM_BASE + 32'hFC, 32'h1234_5678); tick();
    drive(1'b1, 1'b0, RAM_BASE + 32'hFC, 32'd0);
    chk("ram_last", bus.MemData, 32'h1234_5678);
    tick();
    drive(1'b1, 1'b0, RAM_BASE + 32'h100, 32'd0);
    chk("past_end_data", bus.MemData, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("past_end_err", 32'(bus_err), 32'd1);
    drive(1'b0, 1'b1, IO_BASE + 32'h10, 32'd2); tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("err_cleared_1", 32'(bus_err), 32'd0);

    // GPIO out and synchronized input
    drive(1'b0, 1'b1, IO_BASE, 32'h0000_00A5); tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("gpio_out_a5", 32'(gpio_out), 32'h0000_00A5);
    gpio_in = 8'h3C;
    drive(1'b1, 1'b0, IO_BASE + 32'h4, 32'd0);
    chk("gpio_in_0edge", bus.MemData, 32'd0);
    tick();
    chk("gpio_in_1edge", bus.MemData, 32'd0);
    tick();
    chk("gpio_in_2edge", bus.MemData, 32'h0000_003C);

    // Timer compare, W1C racing a match, wrap
    drive(1'b0, 1'b1, IO_BASE + 32'hC, 32'd10); tick();
    drive(1'b0, 1'b1, IO_BASE + 32'h8, 32'd5); tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (5) tick();
    chk("irq_before_match", 32'(timer_irq), 32'd0);
    tick();
    chk("irq_on_match", 32'(timer_irq), 32'd1);
    drive(1'b0, 1'b1, IO_BASE + 32'hC, 32'd14); tick();
    drive(1'b0, 1'b1, IO_BASE + 32'h10, 32'd1); tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("w1c_no_match", 32'(timer_irq), 32'd0);
    tick();
    drive(1'b0, 1'b1, IO_BASE + 32'h10, 32'd1); tick();
    chk("w1c_loses_to_match", 32'(timer_irq), 32'd1);
    tick();
    chk("w1c_after_match", 32'(timer_irq), 32'd0);
    drive(1'b0, 1'b1, IO_BASE + 32'h8, 32'hFFFF_FFFF); tick();
    drive(1'b1, 1'b0, IO_BASE + 32'h8, 32'd0);
    chk("count_loaded", bus.MemData, 32'hFFFF_FFFF);
    tick();
    chk("count_wrapped", bus.MemData, 32'd0);
    drive(1'b0, 1'b1, IO_BASE + 32'hC, 32'hFFFF_FFFF); tick();

    // Misaligned store and first-fault capture
    drive(1'b0, 1'b1, RAM_BASE, 32'h1111_1111); tick();
    drive(1'b0, 1'b1, RAM_BASE + 32'h2, 32'h0000_FFFF); tick();
    drive(1'b1, 1'b0, IO_BASE + 32'h14, 32'd0);
    chk("misalign_err", 32'(bus_err), 32'd1);
    chk("err_addr_first", bus.MemData, 32'h1001_0002);
    tick();
    drive(1'b1, 1'b0, RAM_BASE, 32'd0);
    chk("misalign_dropped", bus.MemData, 32'h1111_1111);
    tick();
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    chk("unmapped_data", bus.MemData, 32'd0);
    tick();
    drive(1'b1, 1'b0, IO_BASE + 32'h14, 32'd0);
    chk("err_addr_held", bus.MemData, 32'h1001_0002);
    tick();
    drive(1'b0, 1'b1, IO_BASE + 32'h10, 32'd2); tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("err_cleared_2", 32'(bus_err), 32'd0);

    // Simultaneous read and write
    drive(1'b0, 1'b1, RAM_BASE + 32'h8, 32'd1); tick();
    drive(1'b1, 1'b1, RAM_BASE + 32'h8, 32'd2);
    chk("conflict_old_data", bus.MemData, 32'd1);
    tick();
    drive(1'b1, 1'b0, RAM_BASE + 32'h8, 32'd0);
    chk("conflict_new_data", bus.MemData, 32'd2);
    tick();
    drive(1'b1, 1'b0, IO_BASE + 32'h10, 32'd0);
    chk("conflict_status", bus.MemData, 32'd6);
    tick();
    drive(1'b0, 1'b1, IO_BASE + 32'h10, 32'd7); tick();

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) gpio_in = 8'($urandom);
      drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 4), rand_addr(), 32'($urandom));
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
